regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameters: none; all widths come from shared package constants.
REQ-002 clk  in  1  rising-edge clock for all storage.
REQ-003 rst  in  1  reset, synchronous and active-high; sampled only at posedge clk.
REQ-004 we_i  in  1  GPR write enable from the write-back stage.
REQ-005 waddr_i  in  5  GPR write address.
REQ-006 wdata_i  in  32  GPR write data.
REQ-007 re1_i  in  1  read-port-1 enable.
REQ-008 raddr1_i  in  5  read-port-1 address.
REQ-009 rdata1_o  out  32  read-port-1 data, combinational.
REQ-010 re2_i  in  1  read-port-2 enable.
REQ-011 raddr2_i  in  5  read-port-2 address.
REQ-012 rdata2_o  out  32  read-port-2 data, combinational.
REQ-013 whilo_i  in  1  HI/LO write enable.
REQ-014 hi_i  in  32  HI write data.
REQ-015 lo_i  in  32  LO write data.
REQ-016 hi_o  out  32  current HI value, registered.
REQ-017 lo_o  out  32  current LO value, registered.

Function
REQ-018 Storage: 32 GPRs x 32 bits; GPR0 reads 0 regardless of any write.
REQ-019 GPR write occurs at posedge clk when we_i=1, waddr_i!=0 and rst=0; write latency is 1 cycle.
REQ-020 A write with waddr_i=0 is discarded with no side effect.
REQ-021 Read port n outputs 0 when rst=1, when ren=0, or when raddrn=0.
REQ-022 Otherwise, read port n outputs GPR[raddrn] combinationally, in the same cycle the address is presented.
REQ-023 Same-cycle read/write collision (we_i=1, waddr_i==raddrn!=0, ren=1) is resolved per REQ-030/031.
REQ-024 Both ports may read the same address simultaneously, and both return identical data.
REQ-025 HI and LO are written together at posedge clk when whilo_i=1 and rst=0.
REQ-026 hi_o and lo_o reflect the stored values; the value written becomes visible the cycle after the write edge.
REQ-027 GPR writes and HI/LO writes are independent and may both occur in the same cycle.

Reset
REQ-028 While rst=1 at posedge clk, all 32 GPRs, HI and LO are cleared to 32'h00000000, and any concurrent write is ignored.
REQ-029 After rst deasserts, every read returns 0 until the addressed register is written.
REQ-029a If rst asserts in the same cycle as a write, reset wins and the register holds 0.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined:
- a colliding read (REQ-023) returns wdata_i in the same cycle (write-through);
- hi_o and lo_o likewise return hi_i and lo_i whenever whilo_i=1.
REQ-031 Without REGFILE_BYPASS_EN:
- a colliding read returns the pre-write stored value, and the new value appears the next cycle;
- hi_o and lo_o are purely registered.

Structure
REQ-032 The shared package holds:
- constants REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, ZERO_WORD=32'h0, ZERO_ADDR=5'h0;
- the enable-level constants WRITE_EN/READ_EN.
REQ-033 One sub-module is natural: regfile_rdport (address decode, enable gating, zero/bypass mux), instantiated twice.
REQ-034 HI/LO storage stays inline in regfile.

Verification
REQ-035 Reset: hold rst=1 for 2 cycles, then read all addresses on both ports with re=1 -> every rdata reads 0, and hi_o=lo_o=0.
REQ-036 Write then read: write 32'hDEADBEEF to r5, then read r5 on both ports the next cycle -> both return DEADBEEF.
REQ-037 Zero register: write 32'hFFFFFFFF to r0, then read r0 -> returns 0.
REQ-038 Collision: r7=32'h1, then in one cycle write 32'h2 to r7 and read r7:
- with REGFILE_BYPASS_EN -> reads 2;
- without -> reads 1, then 2 the next cycle.
REQ-039 Disable and HI/LO: with re1_i=0 and r3=32'h55, rdata1_o=0. Then set whilo_i=1, hi_i=32'hA, lo_i=32'hB -> next cycle hi_o=A, lo_o=B.
REQ-040 Reset mid-write: rst=1 in the same cycle as we_i=1, waddr_i=9, wdata_i=32'h77 -> r9 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared widths, constants and enable levels for the register file and its
// read ports.
//
// Optional feature macro: REGFILE_BYPASS_EN (write-through on GPR read/write
// collisions and HI/LO bypass). Consumed by regfile and regfile_rdport.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_NUM    = 32;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD = 32'h0;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = 5'h0;

    // Active levels of the write/read enables.
    localparam logic WRITE_EN = 1'b1;
    localparam logic READ_EN  = 1'b1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;
    typedef logic [REG_NUM-1:0][REG_DATA_W-1:0] reg_array_t;

    // GPR0 is hard-wired to zero, so a zero address never names real storage.
    function automatic logic addr_is_gpr(input reg_addr_t addr);
        return addr != ZERO_ADDR;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// ----------------------------------------------------------------------------
// regfile_rdport
// One combinational GPR read port: address decode, enable gating, zero mux
// and (optionally) write-through bypass.
//
// Optional feature macro: REGFILE_BYPASS_EN. When defined, the write-port
// inputs are present and a read colliding with a same-cycle write returns the
// write data.
//
// Ports:
//   rst_i     reset; forces the output to zero while asserted
//   re_i      read enable
//   raddr_i   read address
//   regs_i    current contents of all GPRs
//   we_i      write enable            (REGFILE_BYPASS_EN only)
//   waddr_i   write address           (REGFILE_BYPASS_EN only)
//   wdata_i   write data              (REGFILE_BYPASS_EN only)
//   rdata_o   read data, combinational
// ----------------------------------------------------------------------------
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic       rst_i,
    input  logic       re_i,
    input  reg_addr_t  raddr_i,
    input  reg_array_t regs_i,
`ifdef REGFILE_BYPASS_EN
    input  logic       we_i,
    input  reg_addr_t  waddr_i,
    input  reg_word_t  wdata_i,
`endif
    output reg_word_t  rdata_o
);

    always_comb begin
        rdata_o = ZERO_WORD;
        if (!rst_i && (re_i == READ_EN) && addr_is_gpr(raddr_i)) begin
            rdata_o = regs_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
            // Write-through: the value being written this cycle wins over
            // the stale stored copy.
            if ((we_i == WRITE_EN) && (waddr_i == raddr_i)) begin
                rdata_o = wdata_i;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// 32 x 32-bit general-purpose register file with two combinational read
// ports, one write port, and a HI/LO register pair written together.
// GPR0 always reads zero. Reset is synchronous and active-high and clears all
// GPRs plus HI/LO; it overrides any concurrent write.
//
// Optional feature macro: REGFILE_BYPASS_EN. When defined, colliding GPR reads
// return the write data in the same cycle and hi_o/lo_o pass hi_i/lo_i
// through whenever whilo_i is high. When undefined, collisions return the old
// value and hi_o/lo_o are purely registered.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   we_i      GPR write enable
//   waddr_i   GPR write address
//   wdata_i   GPR write data
//   re1_i     read port 1 enable
//   raddr1_i  read port 1 address
//   rdata1_o  read port 1 data (combinational)
//   re2_i     read port 2 enable
//   raddr2_i  read port 2 address
//   rdata2_o  read port 2 data (combinational)
//   whilo_i   HI/LO write enable
//   hi_i      HI write data
//   lo_i      LO write data
//   hi_o      current HI value
//   lo_o      current LO value
// ----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [REG_DATA_W-1:0] wdata_i,
    input  logic                  re1_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    output logic [REG_DATA_W-1:0] rdata1_o,
    input  logic                  re2_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [REG_DATA_W-1:0] rdata2_o,
    input  logic                  whilo_i,
    input  logic [REG_DATA_W-1:0] hi_i,
    input  logic [REG_DATA_W-1:0] lo_i,
    output logic [REG_DATA_W-1:0] hi_o,
    output logic [REG_DATA_W-1:0] lo_o
);

    reg_array_t regs_q, regs_d;
    reg_word_t  hi_q, hi_d;
    reg_word_t  lo_q, lo_d;

    // ------------------------------------------------------------------
    // GPR storage. Entry 0 is never written, so it stays at its reset zero.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if ((we_i == WRITE_EN) && addr_is_gpr(waddr_i)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // HI/LO storage, independent of the GPR write port.
    // ------------------------------------------------------------------
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo_i) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hi_o = whilo_i ? hi_i : hi_q;
    assign lo_o = whilo_i ? lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    regfile_rdport u_rdport1 (
        .rst_i   (rst),
        .re_i    (re1_i),
        .raddr_i (raddr1_i),
        .regs_i  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
`endif
        .rdata_o (rdata1_o)
    );

    regfile_rdport u_rdport2 (
        .rst_i   (rst),
        .re_i    (re2_i),
        .raddr_i (raddr2_i),
        .regs_i  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
`endif
        .rdata_o (rdata2_o)
    );

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile
// Directed scoreboard bench for regfile. Stimulus drives inputs just after
// each rising edge and queues expected outputs; a monitor on the falling edge
// pops the queue and compares against the DUT.
// Honours REGFILE_BYPASS_EN for the collision and HI/LO bypass expectations.
// ----------------------------------------------------------------------------
module tb_regfile;

    localparam int KRd1 = 0;
    localparam int KRd2 = 1;
    localparam int KHi  = 2;
    localparam int KLo  = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .re1_i    (re1_i),
        .raddr1_i (raddr1_i),
        .rdata1_o (rdata1_o),
        .re2_i    (re2_i),
        .raddr2_i (raddr2_i),
        .rdata2_o (rdata2_o),
        .whilo_i  (whilo_i),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    // Monitor: outputs are stable mid-cycle; compare everything queued.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                KRd1:    act = rdata1_o;
                KRd2:    act = rdata2_o;
                KHi:     act = hi_o;
                default: act = lo_o;
            endcase
            checks++;
            if (act === e.exp) begin
                passes++;
            end else begin
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and return to idle inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        we_i     = 1'b0;
        waddr_i  = 5'd0;
        wdata_i  = 32'h0;
        re1_i    = 1'b1;
        raddr1_i = 5'd0;
        re2_i    = 1'b1;
        raddr2_i = 5'd0;
        whilo_i  = 1'b0;
        hi_i     = 32'h0;
        lo_i     = 32'h0;
    endtask

    task automatic write_gpr(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        wdata_i = d;
    endtask

    task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
        raddr1_i = a1;
        raddr2_i = a2;
    endtask

    logic [31:0] coll_exp;
    logic [31:0] hi_exp_now;
    logic [31:0] lo_exp_now;

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        re1_i = 1'b1; raddr1_i = '0; re2_i = 1'b1; raddr2_i = '0;
        whilo_i = 1'b0; hi_i = '0; lo_i = '0;

`ifdef REGFILE_BYPASS_EN
        coll_exp   = 32'h2;
        hi_exp_now = 32'hA;
        lo_exp_now = 32'hB;
`else
        coll_exp   = 32'h1;
        hi_exp_now = 32'h0;
        lo_exp_now = 32'h0;
`endif

        // Two reset cycles; reads are gated to zero while rst is high.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        read_both(5'd5, 5'd31);
        expect_val(KRd1, 32'h0, "rd1_in_reset");
        expect_val(KRd2, 32'h0, "rd2_in_reset");

        // Every address reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            read_both(a[4:0], 5'(31 - a));
            expect_val(KRd1, 32'h0, "rd1_post_reset");
            expect_val(KRd2, 32'h0, "rd2_post_reset");
        end
        expect_val(KHi, 32'h0, "hi_post_reset");
        expect_val(KLo, 32'h0, "lo_post_reset");

        // Write then read on both ports.
        next_cycle();
        write_gpr(5'd5, 32'hDEADBEEF);
        next_cycle();
        read_both(5'd5, 5'd5);
        expect_val(KRd1, 32'hDEADBEEF, "rd1_r5");
        expect_val(KRd2, 32'hDEADBEEF, "rd2_r5");

        // Zero register: write is discarded, same-cycle read also zero.
        next_cycle();
        write_gpr(5'd0, 32'hFFFFFFFF);
        read_both(5'd0, 5'd5);
        expect_val(KRd1, 32'h0, "rd1_r0_during_write");
        expect_val(KRd2, 32'hDEADBEEF, "rd2_r5_unchanged");
        next_cycle();
        read_both(5'd0, 5'd0);
        expect_val(KRd1, 32'h0, "rd1_r0_after_write");
        expect_val(KRd2, 32'h0, "rd2_r0_after_write");

        // Collision on r7.
        next_cycle();
        write_gpr(5'd7, 32'h1);
        next_cycle();
        write_gpr(5'd7, 32'h2);
        read_both(5'd7, 5'd7);
        expect_val(KRd1, coll_exp, "rd1_collision");
        expect_val(KRd2, coll_exp, "rd2_collision");
        next_cycle();
        read_both(5'd7, 5'd7);
        expect_val(KRd1, 32'h2, "rd1_r7_after");
        expect_val(KRd2, 32'h2, "rd2_r7_after");

        // Read disable, plus concurrent GPR and HI/LO writes.
        next_cycle();
        write_gpr(5'd3, 32'h55);
        next_cycle();
        re1_i = 1'b0;
        read_both(5'd3, 5'd3);
        whilo_i = 1'b1;
        hi_i    = 32'hA;
        lo_i    = 32'hB;
        write_gpr(5'd4, 32'h44);
        expect_val(KRd1, 32'h0, "rd1_disabled");
        expect_val(KRd2, 32'h55, "rd2_r3");
        expect_val(KHi, hi_exp_now, "hi_write_cycle");
        expect_val(KLo, lo_exp_now, "lo_write_cycle");
        next_cycle();
        read_both(5'd4, 5'd3);
        expect_val(KHi, 32'hA, "hi_after_write");
        expect_val(KLo, 32'hB, "lo_after_write");
        expect_val(KRd1, 32'h44, "rd1_r4_concurrent");
        expect_val(KRd2, 32'h55, "rd2_r3_again");

        // Reset wins over a concurrent GPR write.
        next_cycle();
        rst = 1'b1;
        write_gpr(5'd9, 32'h77);
        read_both(5'd9, 5'd5);
        expect_val(KRd1, 32'h0, "rd1_r9_in_reset");
        expect_val(KRd2, 32'h0, "rd2_r5_in_reset");
        next_cycle();
        read_both(5'd9, 5'd5);
        expect_val(KRd1, 32'h0, "rd1_r9_after_reset");
        expect_val(KRd2, 32'h0, "rd2_r5_cleared");
        expect_val(KHi, 32'h0, "hi_cleared");
        expect_val(KLo, 32'h0, "lo_cleared");
        next_cycle();
        read_both(5'd7, 5'd3);
        expect_val(KRd1, 32'h0, "rd1_r7_cleared");
        expect_val(KRd2, 32'h0, "rd2_r3_cleared");

        // Let the monitor drain the last expectations.
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
